// File: rtl/detect_defs_pkg.sv
// Shared widths and accumulator re-arm constants for the detection pipeline.
package detect_defs_pkg;

  localparam int unsigned COORD_W = 16;
  localparam int unsigned CNT_W   = 24;

  localparam logic [COORD_W-1:0] COORD_MIN_INIT = '1;
  localparam logic [COORD_W-1:0] COORD_MAX_INIT = '0;

  typedef enum logic [1:0] {
    EvNone,
    EvPixel,
    EvRow,
    EvFrameEnd
  } bbox_event_e;

endpackage

// File: rtl/bbox_axis_range.sv
// One axis of the bounding box: running min/max plus the published copy.
module bbox_axis_range
  import detect_defs_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               update,
  input  logic               rearm,
  input  logic               snapshot,
  input  logic               zero_out,
  input  logic [COORD_W-1:0] coord,
  output logic [COORD_W-1:0] out_min,
  output logic [COORD_W-1:0] out_max
);

  logic [COORD_W-1:0] min_q, max_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      min_q <= COORD_MIN_INIT;
      max_q <= COORD_MAX_INIT;
    end else if (rearm) begin
      min_q <= COORD_MIN_INIT;
      max_q <= COORD_MAX_INIT;
    end else if (update) begin
      if (coord < min_q) min_q <= coord;
      if (coord > max_q) max_q <= coord;
    end
  end

  // Empty frames publish zero bounds rather than the re-arm sentinels.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_min <= '0;
      out_max <= '0;
    end else if (snapshot) begin
      out_min <= zero_out ? '0 : min_q;
      out_max <= zero_out ? '0 : max_q;
    end
  end

endmodule

// File: rtl/bbox_tracker.sv
// Per-frame foreground bounding box and pixel count, published through a
// valid/ready holding register with an overrun counter.
module bbox_tracker
  import detect_defs_pkg::*;
#(
  parameter int unsigned MIN_PIXELS = 16,
  parameter int unsigned OVR_W      = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               hsync,
  input  logic               vsync,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [COORD_W-1:0] frame,
  input  logic               fg,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [COORD_W-1:0] out_x_min,
  output logic [COORD_W-1:0] out_x_max,
  output logic [COORD_W-1:0] out_y_min,
  output logic [COORD_W-1:0] out_y_max,
  output logic [CNT_W-1:0]   out_count,
  output logic [COORD_W-1:0] out_frame,
  output logic               out_empty,
  output logic [OVR_W-1:0]   overrun_cnt
);

  bbox_event_e      ev;
  logic             pix_ev, end_ev, empty_now;
  logic [CNT_W-1:0] count_q;

  // hsync wins over vsync, mirroring the location generator.
  always_comb begin
    ev = EvNone;
    if (en) begin
      if (hsync)      ev = EvRow;
      else if (vsync) ev = EvFrameEnd;
      else if (fg)    ev = EvPixel;
    end
  end

  assign pix_ev    = (ev == EvPixel);
  assign end_ev    = (ev == EvFrameEnd);
  assign empty_now = (count_q < CNT_W'(MIN_PIXELS));

  bbox_axis_range u_x_axis (
    .clk      (clk),
    .reset    (reset),
    .update   (pix_ev),
    .rearm    (end_ev),
    .snapshot (end_ev),
    .zero_out (empty_now),
    .coord    (x),
    .out_min  (out_x_min),
    .out_max  (out_x_max)
  );

  bbox_axis_range u_y_axis (
    .clk      (clk),
    .reset    (reset),
    .update   (pix_ev),
    .rearm    (end_ev),
    .snapshot (end_ev),
    .zero_out (empty_now),
    .coord    (y),
    .out_min  (out_y_min),
    .out_max  (out_y_max)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (end_ev) begin
      count_q <= '0;
    end else if (pix_ev && count_q != '1) begin
      count_q <= count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_count   <= '0;
      out_frame   <= '0;
      out_empty   <= 1'b0;
      overrun_cnt <= '0;
    end else begin
      if (end_ev) begin
        out_valid <= 1'b1;
        out_count <= count_q;
        out_frame <= frame;
        out_empty <= empty_now;
        // A box still waiting with no acceptance this cycle is lost.
        if (out_valid && !out_ready && overrun_cnt != '1) begin
          overrun_cnt <= overrun_cnt + 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bbox_tracker.sv
// Directed bench for bbox_tracker with hand-computed expected boxes.
module tb_bbox_tracker;
  import detect_defs_pkg::*;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               en = 1'b0, hsync = 1'b0, vsync = 1'b0, fg = 1'b0;
  logic [COORD_W-1:0] x = '0, y = '0, frame = '0;
  logic               out_valid, out_ready = 1'b0, out_empty;
  logic [COORD_W-1:0] out_x_min, out_x_max, out_y_min, out_y_max, out_frame;
  logic [CNT_W-1:0]   out_count;
  logic [7:0]         overrun_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bbox_tracker #(
    .MIN_PIXELS (2),
    .OVR_W      (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .hsync       (hsync),
    .vsync       (vsync),
    .x           (x),
    .y           (y),
    .frame       (frame),
    .fg          (fg),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_x_min   (out_x_min),
    .out_x_max   (out_x_max),
    .out_y_min   (out_y_min),
    .out_y_max   (out_y_max),
    .out_count   (out_count),
    .out_frame   (out_frame),
    .out_empty   (out_empty),
    .overrun_cnt (overrun_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then settle just after the edge.
  task automatic cyc(input logic e, input logic h, input logic v, input logic f,
                     input int xi, input int yi, input int fr);
    en = e; hsync = h; vsync = v; fg = f;
    x = COORD_W'(xi); y = COORD_W'(yi); frame = COORD_W'(fr);
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input int xi, input int yi);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, xi, yi, 0);
  endtask

  task automatic vs(input int fr);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 0, 0, fr);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
  endtask

  initial begin
    // 1: reset state, then reset during activity
    idle(); idle();
    chk("rst_valid", out_valid, 0);
    chk("rst_count", out_count, 0);
    chk("rst_ovr", overrun_cnt, 0);
    reset = 1'b0;
    pix(0, 0); pix(7, 3);
    vs(9);
    chk("pre_valid", out_valid, 1);
    chk("pre_xmax", out_x_max, 7);
    chk("pre_frame", out_frame, 9);
    pix(1, 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_xmax", out_x_max, 0);
    chk("arst_count", out_count, 0);
    chk("arst_frame", out_frame, 0);
    idle();
    reset = 1'b0;

    // 2: 8x4 frame, four foreground pixels, consumer always ready
    out_ready = 1'b1;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 8; c++) begin
        cyc(1'b1, 1'b0, 1'b0,
            ((c == 2 || c == 5) && r == 1) || (c == 3 && r == 2) || (c == 2 && r == 3),
            c, r, 0);
      end
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 0, r, 0);
    end
    vs(5);
    chk("f2_valid", out_valid, 1);
    chk("f2_xmin", out_x_min, 2);
    chk("f2_xmax", out_x_max, 5);
    chk("f2_ymin", out_y_min, 1);
    chk("f2_ymax", out_y_max, 3);
    chk("f2_count", out_count, 4);
    chk("f2_empty", out_empty, 0);
    chk("f2_frame", out_frame, 5);
    idle();
    chk("f2_drop", out_valid, 0);

    // 3: one foreground pixel is below MIN_PIXELS
    pix(4, 2);
    vs(6);
    chk("f3_valid", out_valid, 1);
    chk("f3_empty", out_empty, 1);
    chk("f3_xmin", out_x_min, 0);
    chk("f3_xmax", out_x_max, 0);
    chk("f3_ymax", out_y_max, 0);
    chk("f3_count", out_count, 1);
    idle();

    // 4: overrun while stalled, then a one-cycle accept
    out_ready = 1'b0;
    pix(1, 0); pix(3, 1);
    vs(7);
    chk("f4a_count", out_count, 2);
    chk("f4a_ovr", overrun_cnt, 0);
    pix(6, 2); pix(6, 3);
    vs(8);
    chk("f4b_valid", out_valid, 1);
    chk("f4b_ovr", overrun_cnt, 1);
    chk("f4b_frame", out_frame, 8);
    chk("f4b_xmin", out_x_min, 6);
    idle();
    chk("f4_hold_valid", out_valid, 1);
    chk("f4_hold_frame", out_frame, 8);
    out_ready = 1'b1;
    idle();
    out_ready = 1'b0;
    chk("f4_accept", out_valid, 0);

    // 5: fg on row/frame qualifiers and with en low is never counted
    out_ready = 1'b1;
    pix(3, 2); pix(4, 2);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 0, 0, 0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 0, 0, 13);
    chk("f5_hv_nopub", out_valid, 0);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 0, 0, 10);
    chk("f5_valid", out_valid, 1);
    chk("f5_count", out_count, 2);
    chk("f5_xmin", out_x_min, 3);
    chk("f5_ymin", out_y_min, 2);
    chk("f5_frame", out_frame, 10);
    idle();
    chk("f5_drop", out_valid, 0);

    // 6: accept and reload on the same frame-end cycle
    out_ready = 1'b0;
    pix(2, 2); pix(3, 3);
    vs(11);
    chk("f6a_frame", out_frame, 11);
    pix(5, 1); pix(6, 1);
    out_ready = 1'b1;
    vs(12);
    chk("f6_valid", out_valid, 1);
    chk("f6_frame", out_frame, 12);
    chk("f6_xmin", out_x_min, 5);
    chk("f6_ymax", out_y_max, 1);
    chk("f6_ovr", overrun_cnt, 1);
    idle();
    chk("f6_drop", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
